// File: rtl/alu_rr_sched.sv
// alu_rr_sched
// Shares one external ALU between NREQ requesters. A round-robin arbiter
// grants one requester at a time. The block registers that requester's
// operands onto the ALU pins and holds them for ALU_LAT edges, then captures
// the ALU result. It returns the result tagged with the requester ID.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge.
// Ready may depend combinationally on valid. The block never drops a pending
// request.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready per-requester request handshake (at most one ready high)
//   req_a/b/sel     packed per-requester payload, slice i = [i*W +: W]
//   alu_a/b/sel     registered ALU inputs, held while an op is in flight
//   alu_out         ALU result
//   rsp_valid/ready response handshake
//   rsp_id/data     requester tag and captured ALU result
//   busy            high whenever the FSM is not IDLE
//   state_dbg       current FSM state encoding (IDLE=0, WAIT=1, RESP=2)
module alu_rr_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int SELW    = 3,
  parameter int OUTW    = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  input  logic [NREQ*SELW-1:0]     req_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SELW-1:0]          alu_sel,
  input  logic [OUTW-1:0]          alu_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [OUTW-1:0]          rsp_data,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [3:0] LAT = 4'(ALU_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  idx;
  logic            found;
  logic [3:0]      cnt;

  // Round-robin search: the first valid requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Ready is offered only in IDLE. A grant in IDLE is always an accept,
  // because the granted requester is valid by construction.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst)
      req_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found)      state_nxt = WAIT;
      WAIT:    if (cnt == '0)  state_nxt = RESP;
      RESP:    if (rsp_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            alu_a   <= req_a[int'(gnt)*WIDTH +: WIDTH];
            alu_b   <= req_b[int'(gnt)*WIDTH +: WIDTH];
            alu_sel <= req_sel[int'(gnt)*SELW +: SELW];
            rsp_id  <= gnt;
            ptr     <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;
            cnt     <= LAT;
          end
        end
        WAIT: begin
          // ALU inputs stay put; the result is sampled one edge after the
          // counter reaches zero, which covers ALU_LAT edges of ALU delay.
          if (cnt == '0) begin
            rsp_data  <= alu_out;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched.
// The main instance uses ALU_LAT=1 and a registered ALU model. A second
// instance uses ALU_LAT=0 and a combinational ALU model.
// Per-requester driver queues feed the request ports. A reference model
// predicts each grant from the driven request set with plain round-robin
// arithmetic, and pushes the expected tagged result. A monitor pops the
// expected entry and compares it against every presented response.
module tb_alu_rr_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int SELW  = 3;
  localparam int OUTW  = 16;
  localparam int IDW   = 2;
  localparam int LAT   = 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SELW-1:0]  sel;
  } req_t;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [OUTW-1:0] data;
    logic [31:0]     acc;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (ALU_LAT=1) ----------------
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ*SELW-1:0]  req_sel = '0;
  logic [WIDTH-1:0]      alu_a, alu_b;
  logic [SELW-1:0]       alu_sel;
  logic [OUTW-1:0]       alu_out = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [OUTW-1:0]       rsp_data;
  logic                  busy;
  logic [1:0]            state_dbg;

  alu_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SELW(SELW), .OUTW(OUTW), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .state_dbg(state_dbg)
  );

  function automatic logic [OUTW-1:0] alu_f(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                             logic [SELW-1:0] sel);
    case (sel)
      3'd0:    return OUTW'(a) + OUTW'(b);
      3'd1:    return OUTW'(a) - OUTW'(b);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

  // ---------------- second DUT (ALU_LAT=0) ----------------
  logic                  rst0 = 1'b1;
  logic [NREQ-1:0]       req_valid0 = '0;
  logic [NREQ-1:0]       req_ready0;
  logic [NREQ*WIDTH-1:0] req_a0 = '0;
  logic [NREQ*WIDTH-1:0] req_b0 = '0;
  logic [NREQ*SELW-1:0]  req_sel0 = '0;
  logic [WIDTH-1:0]      alu_a0, alu_b0;
  logic [SELW-1:0]       alu_sel0;
  logic [OUTW-1:0]       alu_out0;
  logic                  rsp_valid0;
  logic                  rsp_ready0 = 1'b0;
  logic [IDW-1:0]        rsp_id0;
  logic [OUTW-1:0]       rsp_data0;
  logic                  busy0;
  logic [1:0]            state_dbg0;

  alu_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SELW(SELW), .OUTW(OUTW), .ALU_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst0),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_a(req_a0), .req_b(req_b0), .req_sel(req_sel0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_sel0), .alu_out(alu_out0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_id(rsp_id0), .rsp_data(rsp_data0),
    .busy(busy0), .state_dbg(state_dbg0)
  );

  assign alu_out0 = alu_f(alu_a0, alu_b0, alu_sel0);

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail_now(string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // ---------------- drivers ----------------
  req_t            drv_q [NREQ][$];
  logic [NREQ-1:0] acc_seen = '0;

  task automatic push(int i, req_t p);
    drv_q[i].push_back(p);
  endtask

  function automatic req_t rand_req();
    req_t p;
    p.a   = WIDTH'($urandom_range(0, 255));
    p.b   = WIDTH'($urandom_range(0, 255));
    p.sel = SELW'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic bit queues_empty();
    for (int i = 0; i < NREQ; i++)
      if (drv_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) acc_seen = req_valid & req_ready & {NREQ{~rst}};

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_seen[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
    acc_seen = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (drv_q[i].size() > 0) begin
        req_valid[i]               = 1'b1;
        req_a[i*WIDTH +: WIDTH]    = drv_q[i][0].a;
        req_b[i*WIDTH +: WIDTH]    = drv_q[i][0].b;
        req_sel[i*SELW +: SELW]    = drv_q[i][0].sel;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  exp_t exp_q[$];
  int   mptr  = 0;
  bit   mfree = 1'b1;
  req_t mcur;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int pick;
    exp_t e;
    if (rst) begin
      // Whatever was in flight is discarded; arbitration restarts at 0.
      check("req_ready_in_reset", 32'(req_ready), 32'd0);
      mptr  = 0;
      mfree = 1'b1;
      exp_q.delete();
    end else begin
      check("busy", 32'(busy), 32'(!mfree));
      if (!mfree) begin
        check("alu_a_hold", 32'(alu_a), 32'(mcur.a));
        check("alu_b_hold", 32'(alu_b), 32'(mcur.b));
        check("alu_sel_hold", 32'(alu_sel), 32'(mcur.sel));
      end
      exp_rdy = '0;
      pick    = -1;
      if (mfree)
        for (int k = 0; k < NREQ; k++)
          if (pick < 0 && req_valid[(mptr + k) % NREQ]) pick = (mptr + k) % NREQ;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (pick >= 0) begin
        mcur.a   = req_a[pick*WIDTH +: WIDTH];
        mcur.b   = req_b[pick*WIDTH +: WIDTH];
        mcur.sel = req_sel[pick*SELW +: SELW];
        e.id     = IDW'(pick);
        e.data   = alu_f(mcur.a, mcur.b, mcur.sel);
        e.acc    = 32'(cyc + 1);
        exp_q.push_back(e);
        mptr  = (pick + 1) % NREQ;
        mfree = 1'b0;
      end else if (!mfree && rsp_valid && rsp_ready) begin
        mfree = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          e = exp_q[0];
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          if (!prev_v) check("rsp_latency", 32'(cyc), e.acc + 32'(LAT + 1));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = rsp_valid && !rsp_ready;
    end
  end

  // ---------------- helper tasks ----------------
  task automatic check_reset_outs(string tag);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic wait_drain(string tag, int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (queues_empty() && exp_q.size() == 0 && !busy) break;
      n++;
      if (n >= budget) begin
        fail_now({tag, "_drain_timeout"});
        break;
      end
    end
  endtask

  task automatic wait_cond_rsp_valid(string tag, int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
      if (n >= budget) begin
        fail_now({tag, "_rsp_timeout"});
        break;
      end
    end
  endtask

  task automatic wait_wait_state(string tag, int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (busy && !rsp_valid) break;
      n++;
      if (n >= budget) begin
        fail_now({tag, "_wait_timeout"});
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    req_t p;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1;
    rst  = 1'b0;
    rst0 = 1'b0;

    // Single request: 5 + 3 from requester 0
    p.a = 8'h05; p.b = 8'h03; p.sel = 3'd0;
    push(0, p);
    wait_drain("single", 50);

    // Reset with all four valid: ready must stay low while rst is high,
    // then grants run 0,1,2,3,0 back to back.
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) push(i, rand_req());
    push(0, rand_req());
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset2");
    @(posedge clk); #1;
    rst = 1'b0;
    wait_drain("all_valid", 100);

    // Round-robin wrap: move ptr to 2, then offer req3 (twice) and req1
    push(1, rand_req());
    wait_drain("ptr_to_2", 50);
    @(posedge clk); #1;
    push(3, rand_req());
    push(3, rand_req());
    push(1, rand_req());
    wait_drain("wrap", 100);

    // Backpressure: response held for 10 cycles with req2 waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    push(0, rand_req());
    wait_cond_rsp_valid("bp", 50);
    @(posedge clk); #1;
    push(2, rand_req());
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain("bp", 50);

    // Reset in WAIT: op discarded, arbitration restarts at requester 0
    @(posedge clk); #1;
    push(1, rand_req());
    wait_wait_state("midrst", 50);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("midrst");
    @(posedge clk); #1;
    push(3, rand_req());
    push(0, rand_req());
    wait_drain("after_midrst", 100);

    // Randomized traffic with random response backpressure
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, NREQ - 1)), rand_req());
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain("random", 1000);

    // ALU_LAT=0 instance: req1 computes 0x10 - 0x01
    @(posedge clk); #1;
    req_a0[1*WIDTH +: WIDTH] = 8'h10;
    req_b0[1*WIDTH +: WIDTH] = 8'h01;
    req_sel0[1*SELW +: SELW] = 3'd1;
    req_valid0               = 4'b0010;
    rsp_ready0               = 1'b1;
    @(negedge clk);
    check("lat0_ready", 32'(req_ready0), 32'b0010);
    @(posedge clk); #1;
    req_valid0 = '0;
    @(negedge clk);
    check("lat0_valid_e0", 32'(rsp_valid0), 32'd0);
    check("lat0_busy_e0", 32'(busy0), 32'd1);
    @(negedge clk);
    check("lat0_valid_e1", 32'(rsp_valid0), 32'd1);
    check("lat0_data", 32'(rsp_data0), 32'(alu_f(8'h10, 8'h01, 3'd1)));
    check("lat0_id", 32'(rsp_id0), 32'd1);
    @(negedge clk);
    check("lat0_valid_done", 32'(rsp_valid0), 32'd0);
    check("lat0_busy_done", 32'(busy0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
